// File: rtl/xsfifo_lvl.sv
// Single-clock FIFO with arbitrary depth, registered or fall-through read, occupancy
// level, programmable almost-full/almost-empty flags, synchronous flush and error pulses.
module xsfifo_lvl #(
   parameter int DEPTH  = 4,
   parameter int DW     = 8,
   parameter int FWFT   = 0,
   parameter int AF_LVL = DEPTH - 1,
   parameter int AE_LVL = 1,
   localparam int LW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          flush,
   input  logic          we,
   input  logic [DW-1:0] din,
   output logic          full_n,
   input  logic          re,
   output logic          empty_n,
   output logic [DW-1:0] dout,
   output logic [LW-1:0] level,
   output logic          almost_full,
   output logic          almost_empty,
   output logic          ovf,
   output logic          udf
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
   localparam logic [LW-1:0] AF_L     = LW'(AF_LVL);
   localparam logic [LW-1:0] AE_L     = LW'(AE_LVL);

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          full_n_q, empty_n_q, af_q, ae_q, ovf_q, udf_q;
   logic          we_ok, re_ok;

   // Status flags are registered, so qualification uses the already-registered full/empty.
   assign we_ok = we & full_n_q & ~flush;
   assign re_ok = re & empty_n_q & ~flush;

   // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         level_d = '0;
      end else begin
         if (we_ok) wptr_d = ptr_inc(wptr_q);
         if (re_ok) rptr_d = ptr_inc(rptr_q);
         if (we_ok && !re_ok)      level_d = level_q + LW'(1);
         else if (re_ok && !we_ok) level_d = level_q - LW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         level_q   <= '0;
         full_n_q  <= 1'b1;
         empty_n_q <= 1'b0;
         af_q      <= 1'b0;
         ae_q      <= 1'b1;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         level_q   <= level_d;
         full_n_q  <= (level_d != DEPTH_L);
         empty_n_q <= (level_d != '0);
         af_q      <= (level_d >= AF_L);
         ae_q      <= (level_d <= AE_L);
         ovf_q     <= we & ~full_n_q & ~flush;
         udf_q     <= re & ~empty_n_q & ~flush;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (we_ok) mem_q[wptr_q] <= din;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign dout = mem_q[rptr_q];
      end else begin : g_reg
         logic [DW-1:0] dout_q;
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)      dout_q <= '0;
            else if (re_ok) dout_q <= mem_q[rptr_q];
         end
         assign dout = dout_q;
      end
   endgenerate

   assign full_n       = full_n_q;
   assign empty_n      = empty_n_q;
   assign level        = level_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign ovf          = ovf_q;
   assign udf          = udf_q;

endmodule

// File: doc/xsfifo_lvl.md
# xsfifo_lvl

Single-clock, parametrised FIFO for buffering within one clock domain, including switch ports. Supports any DEPTH ≥ 2, not only powers of two. Offers two read modes selected by parameter: registered-read (standard) or first-word-fall-through (FWFT). Adds an occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and overflow/underflow error pulses, none of which the basic FIFO control provides.

## Interface
- DEPTH, 4, number of entries; any integer ≥ 2; LW = $clog2(DEPTH+1)
- DW, 8, data width in bits
- FWFT, 0, 0 = registered read, 1 = first-word-fall-through
- AF_LVL, DEPTH-1, almost_full asserts when level ≥ AF_LVL; legal range 1..DEPTH
- AE_LVL, 1, almost_empty asserts when level ≤ AE_LVL; legal range 0..DEPTH-1
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of contents
- we  in  1  write request
- din  in  DW  write data
- full_n  out  1  1 = space available
- re  in  1  read request
- empty_n  out  1  1 = data available
- dout  out  DW  read data
- level  out  LW  current occupancy, 0..DEPTH
- almost_full  out  1  level ≥ AF_LVL
- almost_empty  out  1  level ≤ AE_LVL
- ovf  out  1  one-cycle pulse: write attempted while full
- udf  out  1  one-cycle pulse: read attempted while empty

## Operation
- Storage is an internal DEPTH×DW register array. Storage contents are not reset.
- Write and read pointers are binary, range 0..DEPTH-1, and increment by one. The increment after DEPTH-1 wraps to 0; no power-of-two masking.
- Qualified operations:
  - we_ok = we & full_n & ~flush
  - re_ok = re & empty_n & ~flush
- Blocked writes: writes are blocked while full_n=0, even if re_ok occurs in the same cycle.
- Blocked reads: reads are blocked while empty_n=0, even if we_ok occurs in the same cycle.
- Next level:
  - +1 on we_ok only
  - −1 on re_ok only
  - unchanged when both or neither occur
- All status outputs are registered from next-state values and reflect the state after the current edge:
  - level
  - full_n = (next_level != DEPTH)
  - empty_n = (next_level != 0)
  - almost_full
  - almost_empty
- Errors (registered pulses in the cycle after the attempt; suppressed when flush=1):
  - ovf = we & ~full_n
  - udf = re & ~empty_n
- Flush: at the next edge, pointers and level go to 0, empty_n=0, full_n=1, almost_empty=1, almost_full=0. Flush takes priority over we and re in the same cycle. dout is not cleared.
- FWFT=0: dout is a register loaded with mem[rptr] on re_ok; otherwise it holds its value.
- FWFT=1: dout = mem[rptr] combinationally. dout is valid whenever empty_n=1 and don't-care when empty_n=0. re_ok pops the head entry.

## Timing
- Reset values:
  - level=0, full_n=1, empty_n=0, almost_full=0, almost_empty=1, ovf=0, udf=0
  - dout=0 when FWFT=0; rptr=wptr=0
- Write to empty FIFO: empty_n rises 1 cycle after we_ok. In FWFT mode, dout shows that word in the same cycle empty_n rises.
- FWFT=0 read latency: data appears on dout 1 cycle after re_ok.
- FWFT=1 read: after re_ok, the next entry is on dout the following cycle, or empty_n=0 if none remains.
- The write that fills the FIFO drops full_n at the next edge. The read from a full FIFO raises full_n at the next edge.
- Back-to-back: one write and one read per cycle are sustained indefinitely when 0 < level < DEPTH.
- Reset asserted mid-operation: all state returns to reset values immediately and asynchronously; pending data is lost.

## Test plan
- Reset, then fill DEPTH=5, DW=8 (non-power-of-two) with 0x01..0x05 -> full_n=0 after the 5th write and level=5. A 6th we gives ovf=1 for one cycle and level stays 5. Reading out yields 0x01..0x05 in order.
- FWFT=0 vs FWFT=1: write 0xA5 into an empty FIFO ->
  - FWFT=1: dout=0xA5 when empty_n rises.
  - FWFT=0: dout=0xA5 one cycle after re.
- Steady streaming with we=re=1 for 3×DEPTH cycles, starting at level=2 -> level constant at 2, no ovf/udf, and the data sequence is preserved across multiple pointer wraps.
- Simultaneous we and re at level=0 -> write accepted, no read, udf=1, level=1. At level=DEPTH -> read accepted, no write, ovf=1, level=DEPTH-1.
- Thresholds AF_LVL=4, AE_LVL=1 with DEPTH=5 ->
  - almost_full toggles exactly on the 3→4 and 4→3 level transitions.
  - almost_empty toggles exactly on the 1→2 and 2→1 level transitions.
- Flush asserted at level=3 together with we=1 and re=1 -> next cycle level=0, empty_n=0, full_n=1, no data is written, and a subsequent write/read returns only the new data. Async rstn asserted mid-stream -> outputs return to reset values without waiting for a clk edge.
